// File: rtl/stage_mem_pkg.sv
// Shared definitions for the memory-access pipeline stage.
// - Opcodes (L_OP, S_OP, I_OP, NON_OP) and load/store func3 codes.
// - Write-back reset constants (ZERO_WORD, ZERO_REG_ADDR, WRITE_DISABLE).
// - FSM state encodings and helpers that classify a func3 as a memory access.
package stage_mem_pkg;

  localparam logic [6:0] L_OP   = 7'b0000011;
  localparam logic [6:0] S_OP   = 7'b0100011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] NON_OP = 7'b0000000;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [4:0]  ZERO_REG_ADDR = 5'd0;
  localparam logic        WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_BUSY = 2'd1,
    STATE_LAST = 2'd2
  } mem_state_e;

  // True when opcode/func3 describe a load or store this stage performs.
  // Unknown func3 under L_OP/S_OP is not a memory access.
  function automatic logic mem_valid(input logic [6:0] opcode, input logic [2:0] f3);
    mem_valid = 1'b0;
    if (opcode == L_OP) begin
      case (f3)
        F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW: mem_valid = 1'b1;
        default:                             mem_valid = 1'b0;
      endcase
    end else if (opcode == S_OP) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: mem_valid = 1'b1;
        default:             mem_valid = 1'b0;
      endcase
    end
  endfunction

  // Index of the last byte of the access (nbytes-1). Load and store codes
  // share the size encoding in func3[1:0].
  function automatic logic [1:0] mem_last(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: mem_last = 2'd0;
      F3_LH, F3_LHU: mem_last = 2'd1;
      default:       mem_last = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/stage_mem_if.sv
// Byte-wide synchronous RAM bus between the memory stage and the RAM.
// - mem_a_o    byte address
// - mem_dout_o write byte
// - mem_wr_o   write strobe
// - mem_din_i  read byte, valid one cycle after its address
// master = memory stage, slave = RAM.
interface stage_mem_if #(
  parameter int RAM_AW = 17
);
  logic [RAM_AW-1:0] mem_a_o;
  logic [7:0]        mem_dout_o;
  logic              mem_wr_o;
  logic [7:0]        mem_din_i;

  modport master (
    output mem_a_o,
    output mem_dout_o,
    output mem_wr_o,
    input  mem_din_i
  );

  modport slave (
    input  mem_a_o,
    input  mem_dout_o,
    input  mem_wr_o,
    output mem_din_i
  );
endinterface

// File: rtl/stage_mem_load_extend.sv
// Load result extension: turns the raw assembled little-endian bytes into the
// architectural register value.
// - i_func3  load func3 (LB/LH/LW/LBU/LHU)
// - i_raw    raw bytes, byte 0 in [7:0]
// - o_ext    sign/zero-extended word
module stage_mem_load_extend
  import stage_mem_pkg::*;
(
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_raw,
  output logic [31:0] o_ext
);

  always_comb begin
    o_ext = ZERO_WORD;
    case (i_func3)
      F3_LB:   o_ext = {{24{i_raw[7]}}, i_raw[7:0]};
      F3_LH:   o_ext = {{16{i_raw[15]}}, i_raw[15:0]};
      F3_LW:   o_ext = i_raw;
      F3_LBU:  o_ext = {24'd0, i_raw[7:0]};
      F3_LHU:  o_ext = {16'd0, i_raw[15:0]};
      default: o_ext = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage.
// Takes the execute-stage bundle and produces the write-back bundle. Loads and
// stores go over a byte-wide synchronous RAM, one byte per cycle, little-endian;
// every other opcode passes through with one cycle of latency.
// Ports:
// - clk, rst           clock, synchronous active-high reset
// - opcode_i..wdata_i  execute-stage bundle
// - mem                RAM bus (stage_mem_if.master)
// - wd_o/wreg_o/wdata_o  registered write-back bundle
// - stall_req_o        hold request to upstream
// - dbg_state_o        current FSM state
//
// Handshake: the upstream bundle is always considered valid; it is consumed on
// the rising edge where stall_req_o is 0. While stall_req_o is 1 upstream must
// hold every input stable. stall_req_o drops in the final cycle of an access so
// the next bundle is presented right after the completing edge.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int RAM_AW = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] mem_addr_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  stage_mem_if.master mem,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output mem_state_e  dbg_state_o
);

  mem_state_e        r_state;
  mem_state_e        w_state_nx;
  logic [1:0]        r_cnt;
  logic [1:0]        r_last;
  logic [RAM_AW-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_data;
  logic [2:0]        r_f3;
  logic [4:0]        r_wd;
  logic              r_wreg;
  logic              r_is_store;

  logic              w_memop;
  logic              w_ls_op;
  logic              w_busy_end;
  logic [1:0]        w_prev;
  logic [RAM_AW-1:0] w_a;
  logic [7:0]        w_dout;
  logic              w_wr;
  logic              w_stall;
  logic [31:0]       w_raw;
  logic [31:0]       w_ext;

  assign w_memop    = mem_valid(opcode_i, func3_i);
  assign w_ls_op    = (opcode_i == L_OP) || (opcode_i == S_OP);
  assign w_busy_end = (r_cnt == r_last);
  assign w_prev     = r_cnt - 2'd1;

  // Only the low RAM_AW bits of the address are kept; the low bits of a
  // 32-bit wrapping add equal the RAM_AW-bit wrapping add.
  always_comb begin
    w_state_nx = r_state;
    w_stall    = 1'b0;
    w_a        = '0;
    w_dout     = 8'd0;
    w_wr       = 1'b0;
    case (r_state)
      STATE_IDLE: begin
        if (w_memop) begin
          w_stall    = 1'b1;
          w_state_nx = STATE_BUSY;
        end
      end
      STATE_BUSY: begin
        w_a     = r_addr + RAM_AW'(r_cnt);
        w_stall = !(r_is_store && w_busy_end);
        if (r_is_store) begin
          w_wr   = 1'b1;
          w_dout = r_wdata[{r_cnt, 3'b000} +: 8];
        end
        if (w_busy_end) begin
          w_state_nx = r_is_store ? STATE_IDLE : STATE_LAST;
        end
      end
      STATE_LAST: begin
        w_state_nx = STATE_IDLE;
      end
      default: begin
        w_state_nx = STATE_IDLE;
      end
    endcase
  end

  // Final load byte arrives in LAST; merge it before extension.
  always_comb begin
    w_raw = r_data;
    w_raw[{r_last, 3'b000} +: 8] = mem.mem_din_i;
  end

  stage_mem_load_extend u_ext (
    .i_func3 (r_f3),
    .i_raw   (w_raw),
    .o_ext   (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= STATE_IDLE;
      r_cnt      <= 2'd0;
      r_last     <= 2'd0;
      r_addr     <= '0;
      r_wdata    <= ZERO_WORD;
      r_data     <= ZERO_WORD;
      r_f3       <= 3'd0;
      r_wd       <= ZERO_REG_ADDR;
      r_wreg     <= WRITE_DISABLE;
      r_is_store <= 1'b0;
      wd_o       <= ZERO_REG_ADDR;
      wreg_o     <= WRITE_DISABLE;
      wdata_o    <= ZERO_WORD;
    end else begin
      r_state <= w_state_nx;
      case (r_state)
        STATE_IDLE: begin
          if (w_memop) begin
            r_cnt      <= 2'd0;
            r_last     <= mem_last(func3_i);
            r_addr     <= mem_addr_i[RAM_AW-1:0];
            r_wdata    <= wdata_i;
            r_data     <= ZERO_WORD;
            r_f3       <= func3_i;
            r_wd       <= wd_i;
            r_wreg     <= wreg_i;
            r_is_store <= (opcode_i == S_OP);
            // Bubble while the access is in flight.
            wd_o       <= ZERO_REG_ADDR;
            wreg_o     <= WRITE_DISABLE;
            wdata_o    <= ZERO_WORD;
          end else begin
            // Malformed load/store still flows, but never writes a register.
            wd_o    <= wd_i;
            wreg_o  <= wreg_i && !w_ls_op;
            wdata_o <= wdata_i;
          end
        end
        STATE_BUSY: begin
          r_cnt <= r_cnt + 2'd1;
          // Read data lags its address by one cycle.
          if (!r_is_store && (r_cnt != 2'd0)) begin
            r_data[{w_prev, 3'b000} +: 8] <= mem.mem_din_i;
          end
          if (r_is_store && w_busy_end) begin
            wd_o    <= r_wd;
            wreg_o  <= WRITE_DISABLE;
            wdata_o <= ZERO_WORD;
          end
        end
        STATE_LAST: begin
          wd_o    <= r_wd;
          wreg_o  <= r_wreg;
          wdata_o <= w_ext;
        end
        default: begin
          wreg_o <= WRITE_DISABLE;
        end
      endcase
    end
  end

  assign mem.mem_a_o    = w_a;
  assign mem.mem_dout_o = w_dout;
  assign mem.mem_wr_o   = w_wr && !rst;
  assign stall_req_o    = w_stall;
  assign dbg_state_o    = r_state;

endmodule
